// File: rtl/rr_req_tracker_if.sv
// Request/grant bundle between the request tracker and its neighbours.
// master: push/clr/grant driver; slave: the tracker itself.
interface rr_req_tracker_if #(
  parameter int N  = 4,
  parameter int CW = 3
);
  logic [N-1:0]    push;
  logic            clr;
  logic [N-1:0]    grant;
  logic [N-1:0]    req;
  logic [N*CW-1:0] pend_cnt;
  logic [N-1:0]    ovf;
  logic            gnt_err;
  logic [N-1:0]    starve;

  modport master (
    output push, clr, grant,
    input  req, pend_cnt, ovf, gnt_err, starve
  );

  modport slave (
    input  push, clr, grant,
    output req, pend_cnt, ovf, gnt_err, starve
  );
endinterface

// File: rtl/rr_req_tracker.sv
// Per-requester pending counters feeding a round-robin arbiter.
// Ports: clk, rst (sync, high), bus (slave): push/clr/grant in;
//   req/pend_cnt/ovf/gnt_err/starve out.
// Option: STARVE_MON_EN enables per-requester starvation timers.
module rr_req_tracker #(
  parameter int N          = 4,
  parameter int DEPTH      = 7,
  parameter int STARVE_LIM = 15
) (
  input  logic             clk,
  input  logic             rst,
  rr_req_tracker_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] MAX = CW'(DEPTH);

  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] nz, dec, ovf_set, ovf_q;
  logic [N-1:0] req;
  logic         multi, spur, err_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      nz[i]      = cnt_q[i] != '0;
      dec[i]     = bus.grant[i] & nz[i];
      cnt_d[i]   = cnt_q[i];
      ovf_set[i] = 1'b0;
      // Masking with the live grant hides a last pending request
      // from the arbiter in the cycle it is being served.
      req[i]     = cnt_q[i] > CW'(bus.grant[i]);
      unique case ({bus.push[i], dec[i]})
        2'b10: begin
          if (cnt_q[i] == MAX) ovf_set[i] = 1'b1;
          else                 cnt_d[i]   = cnt_q[i] + 1'b1;
        end
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  assign multi = |(bus.grant & (bus.grant - 1'b1));
  assign spur  = |(bus.grant & ~nz);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= (bus.clr ? '0 : ovf_q) | ovf_set;
      err_q <= (bus.clr ? 1'b0 : err_q) | multi | spur;
    end
  end

  assign bus.req      = req;
  assign bus.pend_cnt = cnt_q;
  assign bus.ovf      = ovf_q;
  assign bus.gnt_err  = err_q;

`ifdef STARVE_MON_EN
  localparam int TW = $clog2(STARVE_LIM + 1);
  localparam logic [TW-1:0] TLIM = TW'(STARVE_LIM);

  logic [N-1:0][TW-1:0] tmr_q, tmr_d;
  logic [N-1:0] stv_set, stv_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      tmr_d[i]   = '0;
      stv_set[i] = 1'b0;
      if (req[i] && !bus.grant[i]) begin
        tmr_d[i] = (tmr_q[i] == TLIM) ? TLIM : tmr_q[i] + 1'b1;
      end
      // Flag only on the edge the timer reaches the limit.
      stv_set[i] = (tmr_d[i] == TLIM) && (tmr_q[i] != TLIM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
      stv_q <= '0;
    end else begin
      tmr_q <= tmr_d;
      stv_q <= (bus.clr ? '0 : stv_q) | stv_set;
    end
  end

  assign bus.starve = stv_q;
`else
  logic unused_lim;
  assign unused_lim = (STARVE_LIM > 0);
  assign bus.starve = '0;
`endif
endmodule
